// File: rtl/patch_fetch.sv
// 3x3 patch fetch: reads pixels from a 1-cycle BRAM, reuses columns on partial loads.
// Optional PATCH_FETCH_BACK2BACK_EN accepts the next fetch in DONE during handoff.
module patch_fetch #(
  parameter int DW         = 8,
  parameter int IMG_PIXELS = 784
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_start,
  input  logic          load_full_patch,
  input  logic [9:0]    pixel_addr0,
  input  logic [9:0]    pixel_addr1,
  input  logic [9:0]    pixel_addr2,
  input  logic [9:0]    pixel_addr3,
  input  logic [9:0]    pixel_addr4,
  input  logic [9:0]    pixel_addr5,
  input  logic [9:0]    pixel_addr6,
  input  logic [9:0]    pixel_addr7,
  input  logic [9:0]    pixel_addr8,
  output logic          fetch_ready,
  output logic          mem_rd_en,
  output logic [9:0]    mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          patch_valid,
  input  logic          patch_ready,
  output logic [DW-1:0] pix0,
  output logic [DW-1:0] pix1,
  output logic [DW-1:0] pix2,
  output logic [DW-1:0] pix3,
  output logic [DW-1:0] pix4,
  output logic [DW-1:0] pix5,
  output logic [DW-1:0] pix6,
  output logic [DW-1:0] pix7,
  output logic [DW-1:0] pix8
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [9:0]      addr_q [9];
  logic [9:0]      addr_in [9];
  logic [DW-1:0]   win [9];
  logic [3:0]      k;
  logic [3:0]      cap_k;
  logic            cap_v;
  logic            cap_pad;
  logic            win_init;
  logic [9:0]      cur_addr;
  logic            pad;
  logic            accept;
  logic            eff_full;

  assign addr_in[0] = pixel_addr0;
  assign addr_in[1] = pixel_addr1;
  assign addr_in[2] = pixel_addr2;
  assign addr_in[3] = pixel_addr3;
  assign addr_in[4] = pixel_addr4;
  assign addr_in[5] = pixel_addr5;
  assign addr_in[6] = pixel_addr6;
  assign addr_in[7] = pixel_addr7;
  assign addr_in[8] = pixel_addr8;

  always_comb begin
    cur_addr = '0;
    for (int i = 0; i < 9; i++)
      if (k == 4'(i)) cur_addr = addr_q[i];
  end

  assign pad      = cur_addr >= 10'(IMG_PIXELS);
  assign accept   = fetch_start & fetch_ready;
  assign eff_full = load_full_patch | ~win_init;

  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    patch_valid = 1'b0;
    unique case (state)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_start) state_nxt = READ;
      end
      READ: begin
        mem_addr  = cur_addr;
        mem_rd_en = ~pad;
        if (k == 4'd8) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        patch_valid = 1'b1;
`ifdef PATCH_FETCH_BACK2BACK_EN
        fetch_ready = patch_ready;
        if (patch_ready)
          state_nxt = fetch_start ? READ : IDLE;
`else
        if (patch_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= '0;
      cap_k    <= '0;
      cap_v    <= 1'b0;
      cap_pad  <= 1'b0;
      win_init <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        addr_q[i] <= '0;
        win[i]    <= '0;
      end
    end else begin
      cap_v   <= state == READ;
      cap_k   <= k;
      cap_pad <= pad;
      if (state == READ) k <= k + 4'd1;
      if (state == DRAIN) win_init <= 1'b1;
      if (accept) begin
        for (int i = 0; i < 9; i++)
          addr_q[i] <= addr_in[i];
        k <= eff_full ? 4'd0 : 4'd6;
        // Partial load slides the window one column left.
        if (!eff_full)
          for (int i = 0; i < 6; i++)
            win[i] <= win[i+3];
      end
      if (cap_v)
        for (int i = 0; i < 9; i++)
          if (cap_k == 4'(i))
            win[i] <= cap_pad ? '0 : mem_rdata;
    end
  end

  assign pix0 = win[0];
  assign pix1 = win[1];
  assign pix2 = win[2];
  assign pix3 = win[3];
  assign pix4 = win[4];
  assign pix5 = win[5];
  assign pix6 = win[6];
  assign pix7 = win[7];
  assign pix8 = win[8];

endmodule
